// File: rtl/cache_refill_ctrl.sv
// Refill and flush sequencer for a direct-mapped data cache: hit detect, memory fetch, line fill
// and full-cache invalidate sweep. Optional refill timeout enabled by `define REFILL_TIMEOUT_EN.
module cache_refill_ctrl #(
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TAG_LSB     = 6,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                          iCLK,
  input  logic                          iRSTn,
  input  logic                          iReq,
  input  logic [DATA_WIDTH-1:0]         iAddress,
  input  logic [DATA_WIDTH-TAG_LSB-1:0] iTag,
  input  logic                          iV,
  input  logic                          iFlushAll,
  output logic                          oHit,
  output logic                          oStall,
  output logic                          oMemReq,
  output logic [DATA_WIDTH-1:0]         oMemAddr,
  input  logic                          iMemAck,
  input  logic [DATA_WIDTH-1:0]         iMemData,
  output logic                          oFillEn,
  output logic [INDEX_WIDTH-1:0]        oFillIndex,
  output logic [DATA_WIDTH-TAG_LSB-1:0] oFillTag,
  output logic [DATA_WIDTH-1:0]         oFillData,
  output logic                          oFlush,
  output logic [INDEX_WIDTH-1:0]        oFlushAddress,
`ifdef REFILL_TIMEOUT_EN
  output logic                          oTimeout,
`endif
  output logic                          oBusy
);

  localparam logic [DATA_WIDTH-1:0] WordMask = ~(DATA_WIDTH'(3));

  typedef enum logic [2:0] {StIdle, StReq, StFill, StDone, StFlush} state_e;

  state_e                 state_q;
  logic [DATA_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [INDEX_WIDTH-1:0] flush_cnt_q;
  logic                   pending_q;
  logic                   mem_req_q;
  logic                   fill_en_q;
  logic                   flush_q;
  logic                   hit;

`ifdef REFILL_TIMEOUT_EN
  localparam int unsigned TmoW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  logic [TmoW-1:0] tmo_cnt_q;
  logic            timeout_q;
  assign oTimeout = timeout_q;
`endif

  assign hit = iReq & iV & (iTag == iAddress[DATA_WIDTH-1:TAG_LSB]) & (state_q == StIdle);

  assign oHit          = hit;
  assign oStall        = (iReq & ~hit) | (state_q != StIdle);
  assign oBusy         = (state_q != StIdle);
  assign oMemReq       = mem_req_q;
  assign oMemAddr      = addr_q;
  assign oFillEn       = fill_en_q;
  assign oFillIndex    = addr_q[INDEX_WIDTH+1:2];
  assign oFillTag      = addr_q[DATA_WIDTH-1:TAG_LSB];
  assign oFillData     = data_q;
  assign oFlush        = flush_q;
  assign oFlushAddress = flush_cnt_q;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      data_q      <= '0;
      flush_cnt_q <= '0;
      pending_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      fill_en_q   <= 1'b0;
      flush_q     <= 1'b0;
`ifdef REFILL_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      fill_en_q <= 1'b0;
`ifdef REFILL_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          // A flush wins over a simultaneous miss; the CPU re-misses after the sweep.
          if (iFlushAll || pending_q) begin
            state_q     <= StFlush;
            pending_q   <= 1'b0;
            flush_cnt_q <= '0;
            flush_q     <= 1'b1;
          end else if (iReq && !hit) begin
            state_q   <= StReq;
            addr_q    <= iAddress & WordMask;
            mem_req_q <= 1'b1;
`ifdef REFILL_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        StReq: begin
          if (iFlushAll) pending_q <= 1'b1;
          if (iMemAck) begin
            state_q   <= StFill;
            data_q    <= iMemData;
            mem_req_q <= 1'b0;
            fill_en_q <= 1'b1;
          end
`ifdef REFILL_TIMEOUT_EN
          else if (tmo_cnt_q == TmoLast) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        StFill: begin
          if (iFlushAll) pending_q <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          if (iFlushAll) pending_q <= 1'b1;
          state_q <= StIdle;
        end
        StFlush: begin
          flush_cnt_q <= flush_cnt_q + 1'b1;
          if (flush_cnt_q == '1) begin
            state_q <= StIdle;
            flush_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed self-checking bench for cache_refill_ctrl; inputs change and outputs are sampled
// on the falling clock edge.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic [25:0] tag;
  logic        v;
  logic        flush_all;
  logic        hit;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        fill_en;
  logic [3:0]  fill_index;
  logic [25:0] fill_tag;
  logic [31:0] fill_data;
  logic        flush;
  logic [3:0]  flush_addr;
  logic        busy;
`ifdef REFILL_TIMEOUT_EN
  logic        timeout;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl #(
    .INDEX_WIDTH(4),
    .DATA_WIDTH (32),
    .TAG_LSB    (6),
    .TIMEOUT    (10)
  ) dut (
    .iCLK         (clk),
    .iRSTn        (rst_n),
    .iReq         (req),
    .iAddress     (addr),
    .iTag         (tag),
    .iV           (v),
    .iFlushAll    (flush_all),
    .oHit         (hit),
    .oStall       (stall),
    .oMemReq      (mem_req),
    .oMemAddr     (mem_addr),
    .iMemAck      (mem_ack),
    .iMemData     (mem_data),
    .oFillEn      (fill_en),
    .oFillIndex   (fill_index),
    .oFillTag     (fill_tag),
    .oFillData    (fill_data),
    .oFlush       (flush),
    .oFlushAddress(flush_addr),
`ifdef REFILL_TIMEOUT_EN
    .oTimeout     (timeout),
`endif
    .oBusy        (busy)
  );

  // ctl packs {oMemReq, oFillEn, oFlush, oBusy, oStall}
  logic [4:0] ctl;
  assign ctl = {mem_req, fill_en, flush, busy, stall};

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; addr = '0; tag = '0; v = 1'b0; flush_all = 1'b0;
    mem_ack = 1'b0; mem_data = '0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (ctl !== 5'b00000 || hit !== 1'b0) begin
      err_cnt++; $display("FAIL reset_ctl: got %b hit %b, exp 00000 hit 0", ctl, hit);
    end
    vec_cnt++;
    if ({mem_addr, fill_index, fill_tag, fill_data, flush_addr} !== '0) begin
      err_cnt++; $display("FAIL reset_buses: addr %h idx %h tag %h data %h faddr %h, exp all 0",
                          mem_addr, fill_index, fill_tag, fill_data, flush_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_flush_sweep();
    flush_all = 1'b1;
    @(negedge clk);
    flush_all = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vec_cnt++;
      if (flush !== 1'b1 || flush_addr !== 4'(i) || busy !== 1'b1) begin
        err_cnt++; $display("FAIL sweep_%0d: flush %b addr %0d busy %b, exp 1 %0d 1",
                            i, flush, flush_addr, busy, i);
      end
      flush_all = (i == 5);  // mid-sweep request must not restart the sweep
      @(negedge clk);
    end
    flush_all = 1'b0;
    vec_cnt++;
    if (flush !== 1'b0 || busy !== 1'b0 || flush_addr !== 4'd0) begin
      err_cnt++; $display("FAIL sweep_end: flush %b busy %b addr %0d, exp 0 0 0",
                          flush, busy, flush_addr);
    end
    @(negedge clk);
    vec_cnt++;
    if (flush !== 1'b0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL sweep_norestart: flush %b busy %b, exp 0 0", flush, busy);
    end
  endtask

  task automatic test_miss_refill();
    req = 1'b1; addr = 32'h0000_1234; v = 1'b0; tag = '0;
    #1;
    vec_cnt++;
    if (hit !== 1'b0 || stall !== 1'b1) begin
      err_cnt++; $display("FAIL miss_lookup: hit %b stall %b, exp 0 1", hit, stall);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (ctl !== 5'b10011 || mem_addr !== 32'h0000_1234) begin
        err_cnt++; $display("FAIL miss_req_%0d: ctl %b addr %h, exp 10011 00001234",
                            i, ctl, mem_addr);
      end
    end
    mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0; mem_data = '0;
    vec_cnt++;
    if (ctl !== 5'b01011 || fill_index !== 4'hD || fill_tag !== 26'h48 ||
        fill_data !== 32'hDEAD_BEEF) begin
      err_cnt++; $display("FAIL miss_fill: ctl %b idx %h tag %h data %h, exp 01011 d 48 deadbeef",
                          ctl, fill_index, fill_tag, fill_data);
    end
    v = 1'b1; tag = 26'h48;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== 5'b00011 || hit !== 1'b0) begin
      err_cnt++; $display("FAIL miss_done: ctl %b hit %b, exp 00011 0", ctl, hit);
    end
    @(negedge clk);
    vec_cnt++;
    if (ctl !== 5'b00000 || hit !== 1'b1) begin
      err_cnt++; $display("FAIL miss_rehit: ctl %b hit %b, exp 00000 1", ctl, hit);
    end
    req = 1'b0;
  endtask

  task automatic test_hit();
    req = 1'b1; addr = 32'h0000_0040; v = 1'b1; tag = 26'h1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec_cnt++;
      if (hit !== 1'b1 || ctl !== 5'b00000) begin
        err_cnt++; $display("FAIL hit_%0d: hit %b ctl %b, exp 1 00000", i, hit, ctl);
      end
      @(negedge clk);
    end
    tag = 26'h2;
    #1;
    vec_cnt++;
    if (hit !== 1'b0 || stall !== 1'b1) begin
      err_cnt++; $display("FAIL hit_tagdiff: hit %b stall %b, exp 0 1", hit, stall);
    end
    req = 1'b0; tag = 26'h1;
    #1;
    vec_cnt++;
    if (hit !== 1'b0 || stall !== 1'b0) begin
      err_cnt++; $display("FAIL hit_noreq: hit %b stall %b, exp 0 0", hit, stall);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_data = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== 5'b00000 || fill_data === 32'hFFFF_FFFF) begin
      err_cnt++; $display("FAIL stray_ack: ctl %b data %h, exp 00000 and no capture",
                          ctl, fill_data);
    end
  endtask

  task automatic test_fast_ack();
    req = 1'b1; addr = 32'h0000_03FE; v = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== 5'b10011 || mem_addr !== 32'h0000_03FC) begin
      err_cnt++; $display("FAIL fast_req: ctl %b addr %h, exp 10011 000003fc", ctl, mem_addr);
    end
    mem_ack = 1'b1; mem_data = 32'hA5A5_0F0F;
    @(negedge clk);
    mem_ack = 1'b0; req = 1'b0;
    vec_cnt++;
    if (ctl !== 5'b01011 || fill_index !== 4'hF || fill_tag !== 26'hF ||
        fill_data !== 32'hA5A5_0F0F) begin
      err_cnt++; $display("FAIL fast_fill: ctl %b idx %h tag %h data %h, exp 01011 f f a5a50f0f",
                          ctl, fill_index, fill_tag, fill_data);
    end
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (ctl !== 5'b00000) begin
      err_cnt++; $display("FAIL fast_idle: ctl %b, exp 00000", ctl);
    end
  endtask

  task automatic test_flush_during_refill();
    req = 1'b1; addr = 32'h0000_0080; v = 1'b0;
    @(negedge clk);
    flush_all = 1'b1;
    @(negedge clk);
    flush_all = 1'b0; mem_ack = 1'b1; mem_data = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0; req = 1'b0;
    vec_cnt++;
    if (ctl !== 5'b01011 || fill_index !== 4'h0 || fill_tag !== 26'h2 ||
        fill_data !== 32'h1234_5678) begin
      err_cnt++; $display("FAIL pend_fill: ctl %b idx %h tag %h data %h, exp 01011 0 2 12345678",
                          ctl, fill_index, fill_tag, fill_data);
    end
    @(negedge clk);
    vec_cnt++;
    if (ctl !== 5'b00011) begin
      err_cnt++; $display("FAIL pend_done: ctl %b, exp 00011", ctl);
    end
    @(negedge clk);
    vec_cnt++;
    if (ctl !== 5'b00000) begin
      err_cnt++; $display("FAIL pend_idle: ctl %b, exp 00000", ctl);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      vec_cnt++;
      if (flush !== 1'b1 || flush_addr !== 4'(i)) begin
        err_cnt++; $display("FAIL pend_sweep_%0d: flush %b addr %0d, exp 1 %0d",
                            i, flush, flush_addr, i);
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (flush !== 1'b0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL pend_sweep_end: flush %b busy %b, exp 0 0", flush, busy);
    end
  endtask

  task automatic test_reset_mid_refill();
    req = 1'b1; addr = 32'h0000_2000; v = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (mem_req !== 1'b1) begin
      err_cnt++; $display("FAIL rst_mid_pre: mem_req %b, exp 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (mem_req !== 1'b0 || fill_en !== 1'b0 || busy !== 1'b0 || mem_addr !== '0) begin
      err_cnt++; $display("FAIL rst_mid: mem_req %b fill %b busy %b addr %h, exp 0 0 0 0",
                          mem_req, fill_en, busy, mem_addr);
    end
    req = 1'b0; mem_ack = 1'b1; mem_data = 32'h5555_AAAA;
    @(negedge clk);
    mem_ack = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (ctl !== 5'b00000 || fill_data !== '0) begin
      err_cnt++; $display("FAIL rst_mid_after: ctl %b data %h, exp 00000 0", ctl, fill_data);
    end
  endtask

`ifdef REFILL_TIMEOUT_EN
  task automatic test_timeout();
    req = 1'b1; addr = 32'h0000_0500; v = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (mem_req !== 1'b1 || timeout !== 1'b0) begin
        err_cnt++; $display("FAIL tmo_wait_%0d: mem_req %b timeout %b, exp 1 0",
                            i, mem_req, timeout);
      end
    end
    @(negedge clk);
    req = 1'b0;
    vec_cnt++;
    if (timeout !== 1'b1 || mem_req !== 1'b0 || fill_en !== 1'b0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL tmo_pulse: timeout %b mem_req %b fill %b busy %b, exp 1 0 0 0",
                          timeout, mem_req, fill_en, busy);
    end
    @(negedge clk);
    vec_cnt++;
    if (timeout !== 1'b0 || fill_en !== 1'b0) begin
      err_cnt++; $display("FAIL tmo_end: timeout %b fill %b, exp 0 0", timeout, fill_en);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_flush_sweep();
    test_miss_refill();
    test_hit();
    test_fast_ack();
    test_flush_during_refill();
    test_reset_mid_refill();
`ifdef REFILL_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
